// File: rtl/inst_encoder_pkg.sv
// Shared encoding constants for the instruction encoder and decoder.
// Holds the symbolic op enum, RV32I opcode/funct constants and the halt word.
package enc_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_OR  = 3'd2,
      OP_AND = 3'd3,
      OP_LW  = 3'd4,
      OP_SW  = 3'd5,
      OP_BEQ = 3'd6,
      OP_ILL = 3'd7
   } enc_op_t;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_WORD    = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   // jal x0,0 : a self-loop that parks the core at the end of a loaded image
   localparam logic [31:0] HALT_WORD = 32'h0000_006F;

endpackage

// File: rtl/inst_encoder_if.sv
// Request handshake and IMEM write port of the instruction encoder.
// master = request producer / memory side, slave = encoder.
interface inst_encoder_if #(
   parameter int ADDR_W = 10
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [4:0]        req_rd;
   logic [4:0]        req_rs1;
   logic [4:0]        req_rs2;
   logic [12:0]       req_imm;
   logic              req_last;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;

   modport master (
      output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, req_last,
      input  req_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, req_last,
      output req_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/inst_encoder_pack.sv
// Combinational packer: symbolic op + register/immediate fields -> RV32I word.
// Flags op code 7 as illegal; fields a format does not use are ignored.
module inst_pack
   import enc_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [12:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   // branch offsets are always even, so imm[0] carries no information
   logic unused_imm0;
   assign unused_imm0 = imm[0];

   // select the format and assemble the instruction fields
   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (enc_op_t'(op))
         OP_ADD: word = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OPC_R};
         OP_SUB: word = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OPC_R};
         OP_OR:  word = {F7_BASE, rs2, rs1, F3_OR,      rd, OPC_R};
         OP_AND: word = {F7_BASE, rs2, rs1, F3_AND,     rd, OPC_R};
         OP_LW:  word = {imm[11:0], rs1, F3_WORD, rd, OPC_LOAD};
         OP_SW:  word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
         OP_BEQ: word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                         imm[4:1], imm[11], OPC_BRANCH};
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder/loader: accepts symbolic requests and writes packed
// RV32I words to consecutive IMEM addresses, one write per accepted request.
// Optional macro INST_ENCODER_HALT_EN appends a jal x0,0 word at session end.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting requests, one registered write per legal transfer
// HALT  | emitting the trailing self-loop word (INST_ENCODER_HALT_EN only)
// DONE  | one-cycle end-of-session pulse, then back to IDLE
module inst_encoder
   import enc_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   inst_encoder_if.slave     bus,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [8:0]        word_cnt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd3;
`ifdef INST_ENCODER_HALT_EN
   localparam logic [1:0] ST_HALT = 2'd2;
   localparam logic [1:0] ST_END  = ST_HALT;
`else
   localparam logic [1:0] ST_END  = ST_DONE;
`endif

   localparam logic [8:0]        MAX_CNT = 9'(MAX_WORDS);
   localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(4);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [8:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;

   logic [31:0] pack_word;
   logic        pack_illegal;
   logic        xfer;

   inst_pack u_pack (
      .op      (bus.req_op),
      .rd      (bus.req_rd),
      .rs1     (bus.req_rs1),
      .rs2     (bus.req_rs2),
      .imm     (bus.req_imm),
      .word    (pack_word),
      .illegal (pack_illegal)
   );

   assign bus.req_ready = (state_q == ST_RUN);
   assign xfer          = bus.req_valid && bus.req_ready;

   // session sequencing, address/count tracking and next write contents
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               addr_d  = {base_addr[ADDR_W-1:2], 2'b00};
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         ST_RUN: begin
            if (xfer) begin
               if (pack_illegal) begin
                  err_d = 1'b1;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = pack_word;
                  addr_d    = addr_q + STEP;
                  cnt_d     = cnt_q + 9'd1;
               end
               // limit is checked on the post-write count so the MAX_WORDS-th
               // transfer is the last one accepted
               if (bus.req_last || (cnt_d >= MAX_CNT)) begin
                  state_d = ST_END;
               end
            end
         end
`ifdef INST_ENCODER_HALT_EN
         ST_HALT: begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = HALT_WORD;
            addr_d    = addr_q + STEP;
            cnt_d     = cnt_q + 9'd1;
            state_d   = ST_DONE;
         end
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // state and registered outputs; reset drops any pending write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign err         = err_q;
   assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: a default instance (MAX_WORDS=256)
// and a MAX_WORDS=4 instance share the request stimulus; each has its own
// write scoreboard fed by a field-level reference encoder.
module tb_inst_encoder;

   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          start;
   logic [AW-1:0] base_addr;
   logic          r_valid, r_last;
   logic [2:0]    r_op;
   logic [4:0]    r_rd, r_rs1, r_rs2;
   logic [12:0]   r_imm;

   inst_encoder_if #(.ADDR_W(AW)) if0 ();
   inst_encoder_if #(.ADDR_W(AW)) ifm ();

   assign if0.req_valid = r_valid;
   assign if0.req_op    = r_op;
   assign if0.req_rd    = r_rd;
   assign if0.req_rs1   = r_rs1;
   assign if0.req_rs2   = r_rs2;
   assign if0.req_imm   = r_imm;
   assign if0.req_last  = r_last;
   assign ifm.req_valid = r_valid;
   assign ifm.req_op    = r_op;
   assign ifm.req_rd    = r_rd;
   assign ifm.req_rs1   = r_rs1;
   assign ifm.req_rs2   = r_rs2;
   assign ifm.req_imm   = r_imm;
   assign ifm.req_last  = r_last;

   logic       busy0, done0, err0, busym, donem, errm;
   logic [8:0] wc0, wcm;

   inst_encoder #(.ADDR_W(AW), .MAX_WORDS(256)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .bus(if0.slave), .busy(busy0), .done(done0), .err(err0), .word_cnt(wc0)
   );

   inst_encoder #(.ADDR_W(AW), .MAX_WORDS(4)) u_dut_max (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .bus(ifm.slave), .busy(busym), .done(donem), .err(errm), .word_cnt(wcm)
   );

   int errors = 0;
   int checks = 0;

   // reference model state, index 0 = default DUT, 1 = MAX_WORDS=4 DUT
   logic [AW-1:0] m_addr [2];
   int            m_cnt [2];
   bit            m_err [2];
   int            m_max [2] = '{256, 4};
   logic [AW-1:0] exp_a [2][$];
   logic [31:0]   exp_d [2][$];
   bit            mon_en [2] = '{1'b1, 1'b0};
   int            done_cnt [2] = '{0, 0};
   int            done_base [2];

   bit            acc;
   logic [31:0]   obs_d;
   logic [AW-1:0] obs_a;

   // RV32I encoding from the ISA field layout, built by shifting fields
   function automatic logic [31:0] ref_word(int op, int rd, int rs1, int rs2, int imm);
      int unsigned w, im;
      im = imm;
      w = (rs1 << 15);
      case (op)
         0: w |= (rs2 << 20) | (rd << 7) | 32'h33;
         1: w |= (32'h20 << 25) | (rs2 << 20) | (rd << 7) | 32'h33;
         2: w |= (rs2 << 20) | (6 << 12) | (rd << 7) | 32'h33;
         3: w |= (rs2 << 20) | (7 << 12) | (rd << 7) | 32'h33;
         4: w |= ((im & 32'hFFF) << 20) | (2 << 12) | (rd << 7) | 32'h03;
         5: w |= (((im >> 5) & 32'h7F) << 25) | (rs2 << 20) | (2 << 12)
               | ((im & 32'h1F) << 7) | 32'h23;
         default: w |= (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25)
               | (rs2 << 20) | (((im >> 1) & 32'hF) << 8)
               | (((im >> 11) & 1) << 7) | 32'h63;
      endcase
      return 32'(w);
   endfunction

   function automatic void model_accept(int t, int op, int rd, int rs1, int rs2,
                                        int imm, bit last);
      if (op == 7) begin
         m_err[t] = 1'b1;
      end else begin
         exp_a[t].push_back(m_addr[t]);
         exp_d[t].push_back(ref_word(op, rd, rs1, rs2, imm));
         m_addr[t] = m_addr[t] + AW'(4);
         m_cnt[t]++;
      end
      if (last || m_cnt[t] >= m_max[t]) begin
`ifdef INST_ENCODER_HALT_EN
         exp_a[t].push_back(m_addr[t]);
         exp_d[t].push_back(32'h0000006F);
         m_addr[t] = m_addr[t] + AW'(4);
         m_cnt[t]++;
`endif
      end
   endfunction

   // write scoreboard and done-pulse counter, default DUT
   always @(negedge clk) begin : mon0
      logic [AW-1:0] ea;
      logic [31:0]   ed;
      if (done0) done_cnt[0]++;
      if (mon_en[0] && if0.wr_en) begin
         checks++;
         if (exp_d[0].size() == 0) begin
            errors++;
            $display("FAIL unexpected_write0 addr=%h data=%h", if0.wr_addr, if0.wr_data);
         end else begin
            ea = exp_a[0].pop_front();
            ed = exp_d[0].pop_front();
            if (if0.wr_addr !== ea || if0.wr_data !== ed) begin
               errors++;
               $display("FAIL write0 got %h@%h want %h@%h", if0.wr_data, if0.wr_addr, ed, ea);
            end
         end
      end
   end

   // write scoreboard and done-pulse counter, MAX_WORDS=4 DUT
   always @(negedge clk) begin : monm
      logic [AW-1:0] ea;
      logic [31:0]   ed;
      if (donem) done_cnt[1]++;
      if (mon_en[1] && ifm.wr_en) begin
         checks++;
         if (exp_d[1].size() == 0) begin
            errors++;
            $display("FAIL unexpected_write_max addr=%h data=%h", ifm.wr_addr, ifm.wr_data);
         end else begin
            ea = exp_a[1].pop_front();
            ed = exp_d[1].pop_front();
            if (ifm.wr_addr !== ea || ifm.wr_data !== ed) begin
               errors++;
               $display("FAIL write_max got %h@%h want %h@%h", ifm.wr_data, ifm.wr_addr, ed, ea);
            end
         end
      end
   end

   task automatic start_session(input int base);
      start = 1'b1;
      base_addr = AW'(base);
      @(posedge clk); #1;
      start = 1'b0;
      for (int t = 0; t < 2; t++) begin
         m_addr[t] = AW'(base) & ~AW'(3);
         m_cnt[t] = 0;
         m_err[t] = 1'b0;
         done_base[t] = done_cnt[t];
      end
      checks++;
      if (busy0 !== 1'b1 || err0 !== 1'b0 || wc0 !== 9'd0) begin
         errors++;
         $display("FAIL session_open busy=%b err=%b cnt=%0d want 1 0 0", busy0, err0, wc0);
      end
   endtask

   // offer one request; waits for ready, updates the model, optionally checks
   // the registered write strobe one cycle after the transfer
   task automatic send(input int t, input int op, input int rd, input int rs1,
                       input int rs2, input int imm, input bit last, input int budget,
                       input bit may_stall, input bit post_chk);
      r_valid = 1'b1;
      r_op = 3'(op); r_rd = 5'(rd); r_rs1 = 5'(rs1); r_rs2 = 5'(rs2);
      r_imm = 13'(imm); r_last = last;
      acc = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if ((t == 1) ? ifm.req_ready : if0.req_ready) begin
            @(posedge clk); #1;
            acc = 1'b1;
            break;
         end
         @(negedge clk);
      end
      r_valid = 1'b0;
      if (!acc) begin
         if (!may_stall) begin
            checks++; errors++;
            $display("FAIL handshake_timeout op=%0d got no ready want ready", op);
         end
         return;
      end
      model_accept(t, op, rd, rs1, rs2, imm, last);
      if (post_chk) begin
         @(negedge clk);
         obs_d = (t == 1) ? ifm.wr_data : if0.wr_data;
         obs_a = (t == 1) ? ifm.wr_addr : if0.wr_addr;
         checks++;
         if (((t == 1) ? ifm.wr_en : if0.wr_en) !== (op != 7)) begin
            errors++;
            $display("FAIL write_latency op=%0d wr_en=%b want %b",
                     op, (t == 1) ? ifm.wr_en : if0.wr_en, op != 7);
         end
      end
   endtask

   task automatic finish_session(input int t);
      bit b;
      b = 1'b1;
      for (int i = 0; i < 20 && b; i++) begin
         @(negedge clk);
         b = (t == 1) ? busym : busy0;
      end
      checks++;
      if (b !== 1'b0) begin
         errors++;
         $display("FAIL session_end_timeout t=%0d busy=%b want 0", t, b);
      end
      checks++;
      if (done_cnt[t] - done_base[t] != 1) begin
         errors++;
         $display("FAIL done_pulses t=%0d got %0d want 1", t, done_cnt[t] - done_base[t]);
      end
      checks++;
      if (exp_d[t].size() != 0) begin
         errors++;
         $display("FAIL missing_writes t=%0d got %0d pending want 0", t, exp_d[t].size());
      end
      checks++;
      if (((t == 1) ? wcm : wc0) !== 9'(m_cnt[t]) || ((t == 1) ? errm : err0) !== m_err[t]) begin
         errors++;
         $display("FAIL end_status t=%0d cnt=%0d err=%b want cnt=%0d err=%b", t,
                  (t == 1) ? wcm : wc0, (t == 1) ? errm : err0, m_cnt[t], m_err[t]);
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0 || wc0 !== 9'd0 ||
          if0.wr_en !== 1'b0 || if0.wr_addr !== '0 || if0.wr_data !== '0 ||
          if0.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s busy=%b done=%b err=%b cnt=%0d wr_en=%b addr=%h data=%h rdy=%b want all 0",
                  name, busy0, done0, err0, wc0, if0.wr_en, if0.wr_addr, if0.wr_data, if0.req_ready);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset_state");
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      start_session(32'h040);
      send(0, 0, 1, 2, 3, $urandom_range(0, 8191), 1'b0, 20, 1'b0, 1'b1);
      checks++;
      if (obs_d !== 32'h003100B3 || obs_a !== AW'(32'h040)) begin
         errors++; $display("FAIL add_word got %h@%h want 003100b3@040", obs_d, obs_a);
      end
      send(0, 1, 4, 5, 6, $urandom_range(0, 8191), 1'b1, 20, 1'b0, 1'b1);
      checks++;
      if (obs_d !== 32'h40628233 || obs_a !== AW'(32'h044)) begin
         errors++; $display("FAIL sub_word got %h@%h want 40628233@044", obs_d, obs_a);
      end
      finish_session(0);
   endtask

   task automatic test_mem_ops();
      start_session(32'h100);
      send(0, 4, 5, 1, $urandom_range(0, 31), 8, 1'b0, 20, 1'b0, 1'b1);
      checks++;
      if (obs_d !== 32'h0080A283) begin
         errors++; $display("FAIL lw_word got %h want 0080a283", obs_d);
      end
      send(0, 5, $urandom_range(0, 31), 2, 5, 12, 1'b0, 20, 1'b0, 1'b1);
      checks++;
      if (obs_d !== 32'h00512623) begin
         errors++; $display("FAIL sw_word got %h want 00512623", obs_d);
      end
      send(0, 6, $urandom_range(0, 31), 1, 2, 16, 1'b1, 20, 1'b0, 1'b1);
      checks++;
      if (obs_d !== 32'h00208863 || obs_a !== AW'(32'h108)) begin
         errors++; $display("FAIL beq_word got %h@%h want 00208863@108", obs_d, obs_a);
      end
      finish_session(0);
   endtask

   task automatic test_random_gaps();
      int op;
      start_session($urandom_range(0, 1023));
      for (int i = 0; i < 14; i++) begin
         op = (i == 5) ? 7 : $urandom_range(0, 7);
         send(0, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 8191), i == 13, 20, 1'b0, 1'b1);
         @(posedge clk); #1;
      end
      finish_session(0);
   endtask

   task automatic test_back_to_back();
      start_session($urandom_range(0, 1023));
      for (int i = 0; i < 10; i++) begin
         send(0, $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 8191), i == 9, 20, 1'b0, 1'b1);
      end
      finish_session(0);
   endtask

   task automatic test_wrap();
      start_session(1022);
      send(0, $urandom_range(0, 6), 3, 4, 5, $urandom_range(0, 8191), 1'b0, 20, 1'b0, 1'b1);
      send(0, $urandom_range(0, 6), 6, 7, 8, $urandom_range(0, 8191), 1'b1, 20, 1'b0, 1'b1);
      checks++;
      if (obs_a !== '0) begin
         errors++; $display("FAIL wrap_addr got %h want 000", obs_a);
      end
      finish_session(0);
   endtask

   task automatic test_max_words();
      int n_acc;
      mon_en[0] = 1'b0;
      mon_en[1] = 1'b1;
      n_acc = 0;
      start_session(32'h200);
      for (int i = 0; i < 6; i++) begin
         send(1, $urandom_range(0, 6), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 8191), 1'b0, 5, 1'b1, 1'b1);
         if (acc) begin
            n_acc++;
            if (n_acc == 4) begin
               checks++;
               if (ifm.req_ready !== 1'b0) begin
                  errors++; $display("FAIL max_ready_drop got %b want 0", ifm.req_ready);
               end
            end
         end
      end
      checks++;
      if (n_acc != 4) begin
         errors++; $display("FAIL max_accepted got %0d want 4", n_acc);
      end
      finish_session(1);
      mon_en[1] = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 2; t++) begin
         exp_a[t].delete(); exp_d[t].delete();
      end
      mon_en[0] = 1'b1;
      @(posedge clk); #1;
      start_session(32'h080);
      send(0, 2, 9, 10, 11, 0, 1'b0, 20, 1'b0, 1'b0);
      rst_n = 1'b0;
      for (int t = 0; t < 2; t++) begin
         exp_a[t].delete(); exp_d[t].delete();
      end
      @(negedge clk);
      check_all_zero("reset_mid_session");
      rst_n = 1'b1;
      @(posedge clk); #1;
      start_session(32'h0C0);
      send(0, 3, 12, 13, 14, 0, 1'b1, 20, 1'b0, 1'b1);
      checks++;
      if (obs_d !== ref_word(3, 12, 13, 14, 0) || obs_a !== AW'(32'h0C0)) begin
         errors++; $display("FAIL post_reset_write got %h@%h want %h@0c0",
                            obs_d, obs_a, ref_word(3, 12, 13, 14, 0));
      end
      finish_session(0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      start = 1'b0; base_addr = '0;
      r_valid = 1'b0; r_last = 1'b0; r_op = '0;
      r_rd = '0; r_rs1 = '0; r_rs2 = '0; r_imm = '0;
      test_reset();
      test_basic();
      test_mem_ops();
      test_random_gaps();
      test_back_to_back();
      test_wrap();
      test_max_words();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
